spi_rx_deserializer: RTL
========================

// Module: spi_rx_deserializer
// PURPOSE
//   Receive-side shift stage of the SPI slave: samples MOSI once per clk while ss_n is low,
//   assembles DATA_W-bit words MSB first and presents each on a valid/ready holding register.
//   Sits directly downstream of the pins and upstream of the command/register-file logic.
//   Tracks its own bit position, flags aborted frames, overruns and (optionally) parity errors.
// PARAMETERS
//   DATA_W      10  word width in bits (>=2)
//   PARITY_ODD  0   parity sense when SPI_RX_PARITY_CHECK_EN is defined: 0 = even, 1 = odd
// PORTS
//   clk        in   1       SPI-domain clock; all state changes on posedge
//   rst_n      in   1       synchronous, active-low reset
//   ss_n       in   1       slave select, active low
//   mosi       in   1       serial data in, sampled on posedge clk
//   rx_data    out  DATA_W  received word, valid while rx_valid=1
//   rx_valid   out  1       holding register full
//   rx_ready   in   1       consumer accepts rx_data when rx_valid&&rx_ready
//   busy       out  1       1 while a frame is partially received (state != IDLE)
//   frame_err  out  1       1-cycle pulse: ss_n rose mid-word
//   overrun    out  1       1-cycle pulse: word completed while holding register still full
//   parity_err out  1       1-cycle pulse with word completion on parity mismatch (0 if macro off)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, bit_cnt=0, shift reg=0, rx_data=0, all 1-bit outputs 0.
//     Reset mid-frame discards partial word and any held word.
//   States: IDLE, SHIFT, PAR (PAR only with macro).
//   IDLE: ss_n=0 -> sample mosi as bit DATA_W-1, bit_cnt<=1, ->SHIFT. ss_n=1 -> stay.
//   SHIFT, ss_n=0: shreg<={shreg[DATA_W-2:0],mosi}, bit_cnt++. On the edge sampling bit 0
//     (bit_cnt==DATA_W-1): word complete; bit_cnt<=0; macro off -> stay SHIFT (back-to-back
//     frames, next edge is next word's MSB); macro on -> PAR.
//   PAR, ss_n=0: sample parity bit, word complete at this edge, ->SHIFT with bit_cnt=0.
//   Word complete: if rx_valid=0 or rx_ready=1 in that cycle -> rx_data<=word, rx_valid<=1 next
//     cycle (latency 1 clk after last sampled bit). Else overrun<=1, new word dropped, old kept.
//   rx_valid clears on rx_valid&&rx_ready unless a new word loads in the same edge (stays 1).
//   ss_n=1 in SHIFT with bit_cnt==0 -> IDLE, no error. ss_n=1 in SHIFT with bit_cnt!=0, or in
//     PAR -> frame_err pulse, partial discarded, ->IDLE. Held word unaffected.
//   busy = (state != IDLE). bit_cnt width = $clog2(DATA_W+1); never exceeds DATA_W-1.
// CONFIGURATION
//   SPI_RX_PARITY_CHECK_EN defined: frame is DATA_W data bits + 1 parity bit; parity_err<=1 for
//     one cycle (with rx_valid load) when (^word ^ parity_bit) != PARITY_ODD; word still delivered.
//   Undefined: no PAR state, parity_err tied 0, PARITY_ODD unused.
// TESTING
//   rst_n=0 2 clks, ss_n=1 -> all outputs 0, busy=0.
//   ss_n=0, shift 10'h2A5 MSB first, rx_ready=1 -> rx_valid=1, rx_data=10'h2A5 1 clk after bit 0.
//   Two back-to-back words 10'h3FF,10'h001 with ss_n low 20 clks, rx_ready=0 -> first held,
//     overrun pulse at second completion, rx_data stays 10'h3FF.
//   ss_n rises after 4 bits -> frame_err 1 clk, busy=0, rx_valid unchanged; next frame decodes OK.
//   rst_n=0 mid-word after 6 bits -> IDLE; following full frame 10'h155 received correctly.
//   Macro on, PARITY_ODD=0, word 10'h003 + parity 1 -> parity_err=1, rx_data=10'h003.

Source files
------------

// File: rtl/spi_rx_deserializer.sv
// spi_rx_deserializer: SPI slave MOSI shift stage with valid/ready holding register.
// Optional parity frame bit enabled by defining SPI_RX_PARITY_CHECK_EN.
module spi_rx_deserializer #(
  parameter int DATA_W     = 10,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
`ifdef SPI_RX_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam bit unused_parity_odd = PARITY_ODD;
`endif
  state_t state, state_nx;
  logic [CW-1:0] bit_cnt, cnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, word;
  logic done, ferr, perr, load;
  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    shreg_nx = shreg;
    word     = {shreg[DATA_W-2:0], mosi};
    done     = 1'b0;
    ferr     = 1'b0;
    perr     = 1'b0;
    if (state == IDLE) begin
      if (!ss_n) begin
        state_nx = SHIFT;
        cnt_nx   = CW'(1);
        shreg_nx = word;
      end
    end else if (ss_n) begin
      // Deselect on a word boundary is a clean end of transfer; anywhere else aborts.
      state_nx = IDLE;
      cnt_nx   = '0;
      ferr     = (state != SHIFT) || (bit_cnt != '0);
    end
`ifdef SPI_RX_PARITY_CHECK_EN
    else if (state == PAR) begin
      word     = shreg;
      done     = 1'b1;
      perr     = ((^shreg) ^ mosi) != PARITY_ODD;
      state_nx = SHIFT;
    end else begin
      shreg_nx = word;
      cnt_nx   = (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
      state_nx = (bit_cnt == LAST) ? PAR : SHIFT;
    end
`else
    else begin
      shreg_nx = word;
      cnt_nx   = (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
      done     = (bit_cnt == LAST);
    end
`endif
  end
  assign load = done && (!rx_valid || rx_ready);
  assign busy = (state != IDLE);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      shreg   <= shreg_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_data    <= load ? word : rx_data;
      rx_valid   <= load || (rx_valid && !rx_ready);
      frame_err  <= ferr;
      overrun    <= done && !load;
      parity_err <= perr;
    end
  end
endmodule
